// File: rtl/day3_lobby_k.sv
// day3_lobby_k: streaming max-joltage selector.
// For each bank of decimal digits it selects K digits, keeping their original order, so that
// they form the largest K-digit number. It emits one result per bank and keeps a running total.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   digit_valid  digit/last are valid this cycle (always accepted)
//   digit        decimal digit 0..9; values above 9 are dropped and flagged
//   last         with digit_valid: this digit closes the current bank
//   finish       end of input; no more banks follow
//   bank_valid   1-cycle pulse: bank_result/short_bank are valid
//   bank_result  largest K-digit value of the bank just closed (0 when short)
//   short_bank   with bank_valid: the bank had fewer than K digits
//   bad_digit    sticky: a digit above 9 was received
//   total        running sum of bank results, wraps modulo 2^SUM_W
//   done_        sticky: finish seen and the final bank_valid has been issued
module day3_lobby_k #(
    parameter int unsigned K        = 12,
    parameter int unsigned RESULT_W = 40,
    parameter int unsigned SUM_W    = 48
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                digit_valid,
    input  logic [3:0]          digit,
    input  logic                last,
    input  logic                finish,
    output logic                bank_valid,
    output logic [RESULT_W-1:0] bank_result,
    output logic                short_bank,
    output logic                bad_digit,
    output logic [SUM_W-1:0]    total,
    output logic                done_
);

    localparam int unsigned CntW = $clog2(K + 1);

    // best_q[k] is the largest k-digit subsequence seen so far; entry 0 stays at zero.
    logic [RESULT_W-1:0] best_q [0:K];
    logic [RESULT_W-1:0] best_d [0:K];
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic                bank_valid_q;
    logic [RESULT_W-1:0] bank_result_q;
    logic                short_q;
    logic                bad_q;
    logic [SUM_W-1:0]    total_q;
    logic                done_q;

    logic                accept;
    logic                good;
    logic                close;
    logic                full;
    logic [RESULT_W-1:0] cand;
    logic [RESULT_W-1:0] result;

    always_comb begin
        best_d = best_q;
        cnt_d  = cnt_q;
        cand   = '0;
        // Input is ignored entirely once done_ is up.
        accept = digit_valid && !done_q;
        good   = accept && (digit <= 4'd9);
        close  = accept && last;

        if (good) begin
            // Every length k is updated from the old values of length k-1 and k.
            for (int k = 1; k <= K; k++) begin
                cand = best_q[k-1] * RESULT_W'(10) + RESULT_W'(digit);
                if (int'(cnt_q) >= k) begin
                    best_d[k] = (cand > best_q[k]) ? cand : best_q[k];
                end else if (int'(cnt_q) >= k - 1) begin
                    best_d[k] = cand;
                end
            end
            if (cnt_q != CntW'(K)) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        full   = (cnt_d == CntW'(K));
        result = full ? best_d[K] : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k <= K; k++) begin
                best_q[k] <= '0;
            end
            cnt_q         <= '0;
            bank_valid_q  <= 1'b0;
            bank_result_q <= '0;
            short_q       <= 1'b0;
            bad_q         <= 1'b0;
            total_q       <= '0;
            done_q        <= 1'b0;
        end else begin
            // A close or finish starts a fresh bank; an unterminated bank at finish is dropped.
            if (close || finish) begin
                for (int k = 0; k <= K; k++) begin
                    best_q[k] <= '0;
                end
                cnt_q <= '0;
            end else begin
                best_q <= best_d;
                cnt_q  <= cnt_d;
            end

            bank_valid_q <= close;
            if (close) begin
                bank_result_q <= result;
                short_q       <= !full;
                total_q       <= total_q + SUM_W'(result);
            end

            if (accept && !good) begin
                bad_q <= 1'b1;
            end
            if (finish) begin
                done_q <= 1'b1;
            end
        end
    end

    assign bank_valid  = bank_valid_q;
    assign bank_result = bank_result_q;
    assign short_bank  = short_q;
    assign bad_digit   = bad_q;
    assign total       = total_q;
    assign done_       = done_q;

endmodule
